multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the LEGv8 datapath (regfile, signext, ALU, unified memory).

---
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the LEGv8 datapath. It sequences fetch, decode,
// execute, memory and writeback, and handshakes with a variable-latency memory.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [3:0]  alucontrol,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic [1:0]  fault
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_LDUR,
        C_STUR,
        C_CBZ,
        C_ADD,
        C_SUB,
        C_AND,
        C_ORR
    } class_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t         state_q, state_d;
    class_t         class_q, class_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     fault_q, fault_d;

    class_t         dec_class;
    logic           wait_expired;

    always_comb begin
        dec_class = C_NONE;
        casez (opcode)
            11'b11111000010: dec_class = C_LDUR;
            11'b11111000000: dec_class = C_STUR;
            11'b10110100???: dec_class = C_CBZ;
            11'b10001011000: dec_class = C_ADD;
            11'b11001011000: dec_class = C_SUB;
            11'b10001010000: dec_class = C_AND;
            11'b10101010000: dec_class = C_ORR;
            default:         dec_class = C_NONE;
        endcase
    end

    // The last permitted wait cycle faults only if the memory still has not answered.
    assign wait_expired = (timer_q == TIMER_LAST) && !mem_ack;

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        fault_d    = fault_q;
        timer_d    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alucontrol = ALU_AND;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_DECODE: begin
                class_d = dec_class;
                reg2loc = (dec_class == C_STUR) || (dec_class == C_CBZ);
                if (dec_class == C_NONE) begin
                    fault_d = FAULT_ILLEGAL;
                    state_d = S_ERR;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (class_q)
                    C_LDUR, C_STUR: begin
                        alu_src    = 1'b1;
                        alucontrol = ALU_ADD;
                        reg2loc    = (class_q == C_STUR);
                        state_d    = S_MEM;
                    end
                    C_CBZ: begin
                        reg2loc    = 1'b1;
                        alucontrol = ALU_PASSB;
                        pc_en      = zero;
                        pc_src     = zero;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_ADD: begin
                        alucontrol = ALU_ADD;
                        state_d    = S_WB;
                    end
                    C_SUB: begin
                        alucontrol = ALU_SUB;
                        state_d    = S_WB;
                    end
                    C_AND: begin
                        alucontrol = ALU_AND;
                        state_d    = S_WB;
                    end
                    C_ORR: begin
                        alucontrol = ALU_ORR;
                        state_d    = S_WB;
                    end
                    default: begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = S_ERR;
                    end
                endcase
            end

            S_MEM: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_we     = (class_q == C_STUR);
                alucontrol = ALU_ADD;
                alu_src    = 1'b1;
                if (mem_ack) begin
                    if (class_q == C_STUR) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (class_q == C_LDUR);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_START;
            class_q <= C_NONE;
            timer_q <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

    // Structural invariants of the control outputs; they cost nothing in synthesis.
    mem_we_needs_req: assert property (@(posedge clk) disable iff (!reset) mem_we |-> mem_req);
    pc_src_needs_en:  assert property (@(posedge clk) disable iff (!reset) pc_src |-> pc_en);
    fault_code_legal: assert property (@(posedge clk) disable iff (!reset) fault_q != 2'b11);
    err_absorbing:    assert property (@(posedge clk) disable iff (!reset)
                          (state_q == S_ERR) |=> (state_q == S_ERR) && $stable(fault_q));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// fault/reset sequences, and randomized instructions against a phase-level model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_CBZ  = 11'h5A0;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;

    localparam int K_ILL  = 0;
    localparam int K_LDUR = 1;
    localparam int K_STUR = 2;
    localparam int K_CBZ  = 3;
    localparam int K_ADD  = 4;
    localparam int K_SUB  = 5;
    localparam int K_AND  = 6;
    localparam int K_ORR  = 7;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_en;
        logic       pc_en;
        logic       pc_src;
        logic       reg2loc;
        logic       alu_src;
        logic [3:0] aluc;
        logic       reg_we;
        logic       mem_to_reg;
        logic       instr_done;
    } outs_t;

    typedef struct {
        string       name;
        logic        ack;
        logic        zero;
        logic [10:0] opc;
        logic [14:0] exp;
        logic [1:0]  fexp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, iord, ir_en, pc_en, pc_src, reg2loc, alu_src;
    logic [3:0]  alucontrol;
    logic        reg_we, mem_to_reg, instr_done;
    logic [1:0]  fault;
    logic [14:0] act;

    int checks = 0;
    int fails  = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .alucontrol (alucontrol),
        .reg_we     (reg_we),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .fault      (fault)
    );

    assign act = {mem_req, mem_we, iord, ir_en, pc_en, pc_src, reg2loc, alu_src,
                  alucontrol, reg_we, mem_to_reg, instr_done};

    task automatic applyStimulus(input logic a, input logic z, input logic [10:0] o);
        mem_ack = a;
        zero    = z;
        opcode  = o;
    endtask

    task automatic checkOutput(input string name, input outs_t e, input logic [1:0] fe);
        logic [14:0] ev;
        ev = e;
        checks++;
        if (act !== ev) begin
            fails++;
            $display("[TB] FAIL %s: outputs got %b expected %b at %0t", name, act, ev, $time);
        end
        checks++;
        if (fault !== fe) begin
            fails++;
            $display("[TB] FAIL %s: fault got %b expected %b at %0t", name, fault, fe, $time);
        end
    endtask

    // One clock cycle: drive just after the rising edge, compare at the falling edge.
    task automatic cycle(input string name, input logic a, input logic z,
                         input logic [10:0] o, input outs_t e, input logic [1:0] fe);
        applyStimulus(a, z, o);
        @(negedge clk);
        checkOutput(name, e, fe);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        checkOutput("reset async", '0, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle("start", 1'($urandom), 1'($urandom), 11'($urandom), '0, 2'b00);
    endtask

    function automatic int kind_of(input logic [10:0] o);
        if (o == OP_LDUR) return K_LDUR;
        if (o == OP_STUR) return K_STUR;
        if (o[10:3] == 8'hB4) return K_CBZ;
        if (o == OP_ADD) return K_ADD;
        if (o == OP_SUB) return K_SUB;
        if (o == OP_AND) return K_AND;
        if (o == OP_ORR) return K_ORR;
        return K_ILL;
    endfunction

    function automatic outs_t exp_fetch(input logic a);
        outs_t e = '0;
        e.mem_req = 1'b1;
        e.ir_en   = a;
        e.pc_en   = a;
        return e;
    endfunction

    function automatic outs_t exp_decode(input int k);
        outs_t e = '0;
        e.reg2loc = (k == K_STUR) || (k == K_CBZ);
        return e;
    endfunction

    function automatic outs_t exp_exec(input int k, input logic z);
        outs_t e = '0;
        case (k)
            K_LDUR, K_STUR: begin
                e.alu_src = 1'b1;
                e.aluc    = 4'b0010;
                e.reg2loc = (k == K_STUR);
            end
            K_CBZ: begin
                e.reg2loc    = 1'b1;
                e.aluc       = 4'b0111;
                e.pc_en      = z;
                e.pc_src     = z;
                e.instr_done = 1'b1;
            end
            K_ADD:   e.aluc = 4'b0010;
            K_SUB:   e.aluc = 4'b0110;
            K_ORR:   e.aluc = 4'b0001;
            default: e.aluc = 4'b0000;
        endcase
        return e;
    endfunction

    function automatic outs_t exp_mem(input logic is_store, input logic a);
        outs_t e = '0;
        e.mem_req    = 1'b1;
        e.iord       = 1'b1;
        e.mem_we     = is_store;
        e.alu_src    = 1'b1;
        e.aluc       = 4'b0010;
        e.instr_done = is_store && a;
        return e;
    endfunction

    function automatic outs_t exp_wb(input logic is_load);
        outs_t e = '0;
        e.reg_we     = 1'b1;
        e.mem_to_reg = is_load;
        e.instr_done = 1'b1;
        return e;
    endfunction

    task automatic err_then_reset(input logic [1:0] f);
        repeat (3) cycle("rnd err", 1'($urandom), 1'($urandom), 11'($urandom), '0, f);
        do_reset();
    endtask

    // The memory gets TO request cycles to answer; fw/mw idle cycles precede the ack.
    task automatic run_instr(input logic [10:0] opc, input int fw, input int mw, input logic z);
        int k;
        k = kind_of(opc);
        for (int i = 0; i < TO; i++) begin
            logic a;
            a = (i >= fw);
            cycle("rnd fetch", a, 1'($urandom), 11'($urandom), exp_fetch(a), 2'b00);
            if (a) break;
            if (i == TO - 1) begin
                err_then_reset(2'b10);
                return;
            end
        end
        cycle("rnd decode", 1'($urandom), 1'($urandom), opc, exp_decode(k), 2'b00);
        if (k == K_ILL) begin
            err_then_reset(2'b01);
            return;
        end
        cycle("rnd exec", 1'($urandom), (k == K_CBZ) ? z : 1'($urandom), 11'($urandom),
              exp_exec(k, z), 2'b00);
        if (k == K_CBZ) return;
        if (k == K_LDUR || k == K_STUR) begin
            for (int i = 0; i < TO; i++) begin
                logic a;
                a = (i >= mw);
                cycle("rnd mem", a, 1'($urandom), 11'($urandom), exp_mem(k == K_STUR, a), 2'b00);
                if (a) break;
                if (i == TO - 1) begin
                    err_then_reset(2'b10);
                    return;
                end
            end
            if (k == K_STUR) return;
        end
        cycle("rnd wb", 1'($urandom), 1'($urandom), 11'($urandom), exp_wb(k == K_LDUR), 2'b00);
    endtask

    function automatic vec_t mk(input string n, input logic a, input logic z,
                                input logic [10:0] o, input logic [14:0] e);
        vec_t v;
        v.name = n;
        v.ack  = a;
        v.zero = z;
        v.opc  = o;
        v.exp  = e;
        v.fexp = 2'b00;
        return v;
    endfunction

    initial begin
        logic [10:0] opc;
        int          sel;
        int          fw;
        int          mw;

        // Bit order: req we iord ir_en pc_en pc_src reg2loc alu_src aluc reg_we m2r done
        tbl.push_back(mk("start",       1, 0, OP_ADD,  15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("add fetch",   1, 0, OP_ADD,  15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("add decode",  1, 0, OP_ADD,  15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("add exec",    1, 0, OP_ADD,  15'b0_0_0_0_0_0_0_0_0010_0_0_0));
        tbl.push_back(mk("add wb",      1, 0, OP_ADD,  15'b0_0_0_0_0_0_0_0_0000_1_0_1));
        tbl.push_back(mk("ldur fetch",  1, 0, OP_LDUR, 15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("ldur decode", 1, 0, OP_LDUR, 15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("ldur exec",   1, 0, OP_LDUR, 15'b0_0_0_0_0_0_0_1_0010_0_0_0));
        tbl.push_back(mk("ldur mem w1", 0, 0, OP_LDUR, 15'b1_0_1_0_0_0_0_1_0010_0_0_0));
        tbl.push_back(mk("ldur mem w2", 0, 0, OP_LDUR, 15'b1_0_1_0_0_0_0_1_0010_0_0_0));
        tbl.push_back(mk("ldur mem ak", 1, 0, OP_LDUR, 15'b1_0_1_0_0_0_0_1_0010_0_0_0));
        tbl.push_back(mk("ldur wb",     1, 0, OP_LDUR, 15'b0_0_0_0_0_0_0_0_0000_1_1_1));
        tbl.push_back(mk("stur fetch",  1, 0, OP_STUR, 15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("stur decode", 1, 0, OP_STUR, 15'b0_0_0_0_0_0_1_0_0000_0_0_0));
        tbl.push_back(mk("stur exec",   1, 0, OP_STUR, 15'b0_0_0_0_0_0_1_1_0010_0_0_0));
        tbl.push_back(mk("stur mem",    1, 0, OP_STUR, 15'b1_1_1_0_0_0_0_1_0010_0_0_1));
        tbl.push_back(mk("cbz1 fetch",  1, 1, OP_CBZ,  15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("cbz1 decode", 1, 1, OP_CBZ,  15'b0_0_0_0_0_0_1_0_0000_0_0_0));
        tbl.push_back(mk("cbz1 exec",   1, 1, OP_CBZ,  15'b0_0_0_0_1_1_1_0_0111_0_0_1));
        tbl.push_back(mk("cbz0 fetch",  1, 0, OP_CBZ,  15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("cbz0 decode", 1, 0, OP_CBZ,  15'b0_0_0_0_0_0_1_0_0000_0_0_0));
        tbl.push_back(mk("cbz0 exec",   1, 0, OP_CBZ,  15'b0_0_0_0_0_0_1_0_0111_0_0_1));
        tbl.push_back(mk("sub fetch",   1, 0, OP_SUB,  15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("sub decode",  1, 0, OP_SUB,  15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("sub exec",    1, 0, OP_SUB,  15'b0_0_0_0_0_0_0_0_0110_0_0_0));
        tbl.push_back(mk("sub wb",      1, 0, OP_SUB,  15'b0_0_0_0_0_0_0_0_0000_1_0_1));
        tbl.push_back(mk("orr fetch",   1, 0, OP_ORR,  15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("orr decode",  1, 0, OP_ORR,  15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("orr exec",    1, 0, OP_ORR,  15'b0_0_0_0_0_0_0_0_0001_0_0_0));
        tbl.push_back(mk("orr wb",      1, 0, OP_ORR,  15'b0_0_0_0_0_0_0_0_0000_1_0_1));
        tbl.push_back(mk("and fetch",   1, 0, OP_AND,  15'b1_0_0_1_1_0_0_0_0000_0_0_0));
        tbl.push_back(mk("and decode",  1, 0, OP_AND,  15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("and exec",    1, 1, OP_AND,  15'b0_0_0_0_0_0_0_0_0000_0_0_0));
        tbl.push_back(mk("and wb",      1, 0, OP_AND,  15'b0_0_0_0_0_0_0_0_0000_1_0_1));

        $display("[TB] reset held for 3 cycles");
        repeat (3) begin
            @(negedge clk);
            checkOutput("in reset", '0, 2'b00);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] directed vector table");
        foreach (tbl[i])
            cycle(tbl[i].name, tbl[i].ack, tbl[i].zero, tbl[i].opc, tbl[i].exp, tbl[i].fexp);

        $display("[TB] illegal opcode");
        cycle("ill fetch", 1, 0, 11'h000, 15'b1_0_0_1_1_0_0_0_0000_0_0_0, 2'b00);
        cycle("ill decode", 1, 0, 11'h000, '0, 2'b00);
        for (int i = 0; i < 4; i++)
            cycle("ill err", 1'(i % 2), 1, OP_LDUR, '0, 2'b01);
        do_reset();

        $display("[TB] fetch timeout");
        for (int i = 0; i < TO; i++)
            cycle("to fetch wait", 0, 0, OP_ADD, 15'b1_0_0_0_0_0_0_0_0000_0_0_0, 2'b00);
        cycle("to err", 1, 0, OP_ADD, '0, 2'b10);
        cycle("to err hold", 1, 0, OP_ADD, '0, 2'b10);
        do_reset();

        $display("[TB] ack on the last permitted cycle");
        for (int i = 0; i < TO - 1; i++)
            cycle("late fetch wait", 0, 0, OP_ADD, 15'b1_0_0_0_0_0_0_0_0000_0_0_0, 2'b00);
        cycle("late fetch ack", 1, 0, OP_ADD, 15'b1_0_0_1_1_0_0_0_0000_0_0_0, 2'b00);
        cycle("late decode", 0, 0, OP_ADD, '0, 2'b00);
        cycle("late exec", 0, 0, OP_ADD, 15'b0_0_0_0_0_0_0_0_0010_0_0_0, 2'b00);
        cycle("late wb", 0, 0, OP_ADD, 15'b0_0_0_0_0_0_0_0_0000_1_0_1, 2'b00);

        $display("[TB] reset in the middle of a store access");
        cycle("mid fetch", 1, 0, OP_STUR, 15'b1_0_0_1_1_0_0_0_0000_0_0_0, 2'b00);
        cycle("mid decode", 1, 0, OP_STUR, 15'b0_0_0_0_0_0_1_0_0000_0_0_0, 2'b00);
        cycle("mid exec", 1, 0, OP_STUR, 15'b0_0_0_0_0_0_1_1_0010_0_0_0, 2'b00);
        applyStimulus(0, 0, OP_STUR);
        @(negedge clk);
        checkOutput("mid mem before reset", 15'b1_1_1_0_0_0_0_1_0010_0_0_0, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid mem after reset", '0, 2'b00);
        mem_ack = 1'b1;
        #1;
        checkOutput("mid mem ack in reset", '0, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle("mid restart", 1, 0, OP_STUR, '0, 2'b00);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 9:    opc = OP_LDUR;
                1:       opc = OP_STUR;
                2:       opc = {8'hB4, 3'($urandom)};
                3:       opc = OP_ADD;
                4:       opc = OP_SUB;
                5:       opc = OP_AND;
                6:       opc = OP_ORR;
                default: opc = 11'($urandom);
            endcase
            fw = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
            mw = ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            run_instr(opc, fw, mw, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
